// File: rtl/rf_seq_pkg.sv
// Shared opcode/state types for the register-file command sequencer.
package rf_seq_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_COPY = 3'd2,
    OP_ADD  = 3'd3,
    OP_SWAP = 3'd4,
    OP_FILL = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_SWAP2 = 3'd2,
    ST_SWEEP = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Opcodes 6 and 7 are reserved and run as NOP.
  function automatic logic is_reserved(input logic [OP_W-1:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/rf_sweep_ctr.sv
// Address counter for FILL sweeps; last flags the final register address.
module rf_sweep_ctr #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] cnt,
  output logic          last
);

  // Counter register, clear has priority over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= {AW{1'b0}};
    end else if (clr) begin
      cnt <= {AW{1'b0}};
    end else if (inc) begin
      cnt <= cnt + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  assign last = (cnt == {AW{1'b1}});

endmodule

// File: rtl/rf_op_seq.sv
// Register-file command sequencer: one command per handshake, done pulse once committed.
// Optional cmd_err output for reserved opcodes when RF_OP_SEQ_ERR_EN is defined.
module rf_op_seq
  import rf_seq_pkg::*;
#(
  parameter int BW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_x,
  input  logic [AW-1:0] cmd_y,
  input  logic [BW-1:0] cmd_imm,
  output logic          busy,
  output logic          done,
`ifdef RF_OP_SEQ_ERR_EN
  output logic          cmd_err,
`endif
  output logic [AW-1:0] rf_ra,
  output logic [AW-1:0] rf_rb,
  input  logic [BW-1:0] rf_a,
  input  logic [BW-1:0] rf_b,
  output logic [AW-1:0] rf_rd,
  output logic [BW-1:0] rf_d,
  output logic          rf_writed
);

  state_e        state_r;
  logic [2:0]    op_r;
  logic [AW-1:0] x_r;
  logic [AW-1:0] y_r;
  logic [BW-1:0] imm_r;
  logic [BW-1:0] tmp_r;
  logic [AW-1:0] cnt_s;
  logic          last_s;
  logic          ctr_clr_s;
  logic          ctr_inc_s;

  assign ctr_clr_s = ((state_r == ST_IDLE) && cmd_valid && (cmd_op == OP_FILL)) ||
                     ((state_r == ST_SWEEP) && last_s);
  assign ctr_inc_s = (state_r == ST_SWEEP);

  rf_sweep_ctr #(.AW(AW)) u_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (ctr_clr_s),
    .inc  (ctr_inc_s),
    .cnt  (cnt_s),
    .last (last_s)
  );

  // Sequencer FSM with command latch and SWAP holding register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      op_r    <= 3'd0;
      x_r     <= {AW{1'b0}};
      y_r     <= {AW{1'b0}};
      imm_r   <= {BW{1'b0}};
      tmp_r   <= {BW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_r  <= cmd_op;
            x_r   <= cmd_x;
            y_r   <= cmd_y;
            imm_r <= cmd_imm;
            case (cmd_op)
              OP_LOAD, OP_COPY, OP_ADD, OP_SWAP: state_r <= ST_EXEC;
              OP_FILL:                           state_r <= ST_SWEEP;
              default:                           state_r <= ST_DONE;
            endcase
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (op_r == OP_SWAP) begin
            tmp_r   <= rf_a;
            state_r <= ST_SWAP2;
          end else begin
            state_r <= ST_DONE;
          end
        end
        ST_SWAP2: state_r <= ST_DONE;
        ST_SWEEP: state_r <= last_s ? ST_DONE : ST_SWEEP;
        ST_DONE:  state_r <= ST_IDLE;
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign done      = (state_r == ST_DONE);
`ifdef RF_OP_SEQ_ERR_EN
  assign cmd_err   = (state_r == ST_DONE) && is_reserved(op_r);
`endif

  // Register-file port drive; everything idles at zero outside write states.
  always_comb begin
    rf_ra     = {AW{1'b0}};
    rf_rb     = {AW{1'b0}};
    rf_rd     = {AW{1'b0}};
    rf_d      = {BW{1'b0}};
    rf_writed = 1'b0;
    case (state_r)
      ST_EXEC: begin
        rf_ra     = x_r;
        rf_rb     = y_r;
        rf_rd     = x_r;
        rf_writed = 1'b1;
        case (op_r)
          OP_LOAD: rf_d = imm_r;
          OP_COPY: rf_d = rf_b;
          OP_ADD:  rf_d = rf_a + rf_b;
          OP_SWAP: rf_d = rf_b;
          default: rf_d = {BW{1'b0}};
        endcase
      end
      ST_SWAP2: begin
        rf_rd     = y_r;
        rf_d      = tmp_r;
        rf_writed = 1'b1;
      end
      ST_SWEEP: begin
        rf_rd     = cnt_s;
        rf_d      = imm_r;
        rf_writed = 1'b1;
      end
      default: begin
        rf_writed = 1'b0;
      end
    endcase
  end

endmodule
